// File: rtl/fpu_div_sequencer_pkg.sv
// Shared types for the fpuDiv issue/collect sequencer: operand format,
// divider condition codes and status flags, sequencer state encoding.
package fpu_div_sequencer_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } opStatusFlag_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_CLEAR,
    S_RESP
  } fpuDivSeqState_t;

  // Canonical quiet NaN: sign 0, exponent all ones, frac MSB set.
  localparam fp16_t FPU_QNAN = '{sign: 1'b0, exp: 5'h1F, frac: 10'h200};

endpackage

// File: rtl/fpu_div_sequencer_if.sv
// Request/response handshake plus the fpuDiv coprocessor connection.
// master = requester/consumer/divider side, slave = the sequencer.
interface fpu_div_sequencer_if
  import fpu_div_sequencer_pkg::*;
#(
  parameter type FP_T  = fp16_t,
  parameter int  TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  FP_T              in_a;
  FP_T              in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  FP_T              out_result;
  logic [TAG_W-1:0] out_tag;
  condCode_t        out_cond;
  opStatusFlag_t    out_flags;
  logic             out_timeout;

  FP_T              div_in1;
  FP_T              div_in2;
  logic             div_start;
  logic             div_reset;
  logic             div_done;
  FP_T              div_out;
  condCode_t        div_cond;
  opStatusFlag_t    div_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
           div_done, div_out, div_cond, div_flags,
    input  in_ready, out_valid, out_result, out_tag, out_cond, out_flags,
           out_timeout, div_in1, div_in2, div_start, div_reset
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
           div_done, div_out, div_cond, div_flags,
    output in_ready, out_valid, out_result, out_tag, out_cond, out_flags,
           out_timeout, div_in1, div_in2, div_start, div_reset
  );

endinterface

// File: rtl/fpu_div_seq_wdog.sv
// BUSY-phase watchdog: counts enabled cycles since the last clear and
// flags expiry once the count reaches LIMIT.
module fpu_div_seq_wdog
  import fpu_div_sequencer_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  assign o_expired = i_enable && (r_count == CW'(LIMIT));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_div_sequencer.sv
// Issue/collect sequencer in front of fpuDiv: holds operands, pulses start,
// collects the result, then clears the divider. Optional watchdog: FPU_DIV_SEQ_TIMEOUT_EN.
module fpu_div_sequencer
  import fpu_div_sequencer_pkg::*;
#(
  parameter type FP_T  = fp16_t,
`ifdef FPU_DIV_SEQ_TIMEOUT_EN
  parameter int  TIMEOUT_CYCLES = 64,
`endif
  parameter int  TAG_W = 4
) (
  input logic                clock,
  input logic                reset,
  fpu_div_sequencer_if.slave bus
);

  fpuDivSeqState_t  r_state;
  FP_T              r_a;
  FP_T              r_b;
  FP_T              r_result;
  logic [TAG_W-1:0] r_tag;
  condCode_t        r_cond;
  opStatusFlag_t    r_flags;
  logic             w_in_ready;
  logic             w_accept;

  // Acceptance depends only on state and out_ready, never on in_valid.
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == S_RESP);
  assign bus.out_result = r_result;
  assign bus.out_tag    = r_tag;
  assign bus.out_cond   = r_cond;
  assign bus.out_flags  = r_flags;
  assign bus.div_in1    = r_a;
  assign bus.div_in2    = r_b;
  assign bus.div_start  = (r_state == S_START);
  // fpuDiv parks in DONE, so it needs a reset pulse between operations.
  assign bus.div_reset  = reset || (r_state == S_CLEAR);

`ifdef FPU_DIV_SEQ_TIMEOUT_EN
  logic r_timeout;
  logic w_expired;

  fpu_div_seq_wdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (r_state == S_START),
    .i_enable (r_state == S_BUSY),
    .o_expired(w_expired)
  );

  assign bus.out_timeout = r_timeout;
`else
  assign bus.out_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_cond   <= '0;
      r_flags  <= '0;
`ifdef FPU_DIV_SEQ_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a   <= bus.in_a;
        r_b   <= bus.in_b;
        r_tag <= bus.in_tag;
      end
      case (r_state)
        S_IDLE:  if (bus.in_valid) r_state <= S_START;
        S_START: r_state <= S_BUSY;
        S_BUSY: begin
          // done wins over a simultaneous watchdog expiry
          if (bus.div_done) begin
            r_result <= bus.div_out;
            r_cond   <= bus.div_cond;
            r_flags  <= bus.div_flags;
`ifdef FPU_DIV_SEQ_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            r_state  <= S_CLEAR;
          end
`ifdef FPU_DIV_SEQ_TIMEOUT_EN
          else if (w_expired) begin
            r_result  <= FP_T'(FPU_QNAN);
            r_cond    <= '0;
            r_flags   <= '{invalid: 1'b1, default: 1'b0};
            r_timeout <= 1'b1;
            r_state   <= S_CLEAR;
          end
`endif
        end
        S_CLEAR: r_state <= S_RESP;
        S_RESP: begin
          if (bus.out_ready) begin
            r_state <= bus.in_valid ? S_START : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_sequencer.sv
// Directed bench for fpu_div_sequencer with a behavioural fpuDiv stub
// (normal latency, never-done, and done-stuck-high modes).
module tb_fpu_div_sequencer;
  import fpu_div_sequencer_pkg::*;

  localparam int TO = 64;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   stub_mode;   // 0 normal, 1 never done, 2 done stuck high

  logic       r_stub_done;
  logic       r_stub_busy;
  logic [3:0] r_stub_cnt;

  fpu_div_sequencer_if #(.FP_T(fp16_t), .TAG_W(4)) bus ();

  fpu_div_sequencer dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Divider stub: fixed quotient table, done after a short latency, held until div_reset.
  always @(posedge clock) begin
    if (bus.div_reset) begin
      r_stub_done <= 1'b0;
      r_stub_busy <= 1'b0;
      r_stub_cnt  <= '0;
    end else if (bus.div_start) begin
      r_stub_busy <= 1'b1;
      r_stub_cnt  <= '0;
    end else if (r_stub_busy && stub_mode == 0) begin
      if (r_stub_cnt == 4'd3) begin
        r_stub_done <= 1'b1;
        r_stub_busy <= 1'b0;
      end
      r_stub_cnt <= r_stub_cnt + 4'd1;
    end
  end

  always_comb begin
    bus.div_done  = (stub_mode == 2) || r_stub_done;
    bus.div_out   = '0;
    bus.div_cond  = '0;
    bus.div_flags = '0;
    if (bus.div_in1 == 16'h4600 && bus.div_in2 == 16'h4000) begin
      bus.div_out = 16'h4200;
    end else if (bus.div_in1 == 16'h3C00 && bus.div_in2 == 16'h4200) begin
      bus.div_out           = 16'h3555;
      bus.div_flags.inexact = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.div_start !== 1'b0) begin bad++; $display("FAIL rst_div_start: got %b want 0", bus.div_start); end
    total++; if (bus.div_reset !== 1'b1) begin bad++; $display("FAIL rst_div_reset: got %b want 1", bus.div_reset); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    total++; if ({bus.out_result, bus.out_tag, bus.out_cond, bus.out_flags} !== 29'd0) begin
      bad++; $display("FAIL rst_out_regs: got %h want 0", {bus.out_result, bus.out_tag, bus.out_cond, bus.out_flags});
    end
    total++; if (bus.out_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", bus.out_timeout); end
    reset = 1'b0;
    tick();
    total++; if (bus.div_reset !== 1'b0) begin bad++; $display("FAIL rst_release_div_reset: got %b want 0", bus.div_reset); end
  endtask

  task automatic test_basic();
    int starts, resets, n, first_done, last_reset;
    bus.out_ready = 1'b1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle_ready: got %b want 1", bus.in_ready); end
    issue(16'h4600, 16'h4000, 4'd3);
    total++; if (bus.div_in1 !== 16'h4600 || bus.div_in2 !== 16'h4000) begin
      bad++; $display("FAIL basic_operands: got %h/%h want 4600/4000", bus.div_in1, bus.div_in2);
    end
    starts = 0; resets = 0; first_done = -1; last_reset = -1; n = 0;
    while (!bus.out_valid && n < 30) begin
      if (bus.div_start) starts++;
      if (bus.div_reset) begin resets++; last_reset = n; end
      if (bus.div_done && first_done < 0) first_done = n;
      tick();
      n++;
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1 (cycle budget)", bus.out_valid); end
    total++; if (starts != 1) begin bad++; $display("FAIL basic_start_pulses: got %0d want 1", starts); end
    total++; if (resets != 1 || last_reset != n - 1) begin
      bad++; $display("FAIL basic_clear_pulse: got count %0d at %0d want 1 at %0d", resets, last_reset, n - 1);
    end
    total++; if (n - first_done != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", n - first_done); end
    total++; if (bus.out_result !== 16'h4200) begin bad++; $display("FAIL basic_result: got %h want 4200", bus.out_result); end
    total++; if (bus.out_tag !== 4'd3) begin bad++; $display("FAIL basic_tag: got %0d want 3", bus.out_tag); end
    total++; if (bus.out_flags !== 5'b00000 || bus.out_cond !== 4'b0000) begin
      bad++; $display("FAIL basic_status: got %b/%b want 0000/00000", bus.out_cond, bus.out_flags);
    end
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_back_idle: got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.out_ready = 1'b0;
    issue(16'h3C00, 16'h4200, 4'd5);
    wait_valid(30, n);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1 (cycle budget)", bus.out_valid); end
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h3555 || bus.in_ready !== 1'b0 || bus.out_tag !== 4'd5) begin
        bad++; $display("FAIL bp_hold[%0d]: got v%b r%h rdy%b t%0d want v1 r3555 rdy0 t5",
                        i, bus.out_valid, bus.out_result, bus.in_ready, bus.out_tag);
      end
      tick();
    end
    total++; if (bus.out_flags !== 5'b00001) begin bad++; $display("FAIL bp_flags: got %b want 00001", bus.out_flags); end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_follows_out_ready: got %b want 1", bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.out_ready = 1'b1;
    issue(16'h4600, 16'h4000, 4'd1);
    wait_valid(30, n);
    total++; if (bus.out_result !== 16'h4200 || bus.out_tag !== 4'd1) begin
      bad++; $display("FAIL b2b_first: got %h t%0d want 4200 t1", bus.out_result, bus.out_tag);
    end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_resp_ready: got %b want 1", bus.in_ready); end
    issue(16'h3C00, 16'h4200, 4'd2);
    total++; if (bus.div_start !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_no_bubble: got start %b valid %b want 1 0", bus.div_start, bus.out_valid);
    end
    total++; if (bus.div_in1 !== 16'h3C00 || bus.div_in2 !== 16'h4200) begin
      bad++; $display("FAIL b2b_operands: got %h/%h want 3c00/4200", bus.div_in1, bus.div_in2);
    end
    wait_valid(30, n);
    total++; if (bus.out_result !== 16'h3555 || bus.out_tag !== 4'd2) begin
      bad++; $display("FAIL b2b_second: got %h t%0d want 3555 t2", bus.out_result, bus.out_tag);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  seen;
    bus.out_ready = 1'b1;
    issue(16'h4600, 16'h4000, 4'd7);
    tick();
    total++; if (bus.div_start !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_busy: got start %b valid %b want 0 0", bus.div_start, bus.out_valid);
    end
    reset = 1'b1;
    #1;
    total++; if (bus.div_reset !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_async: got dr%b v%b rdy%b want 1 0 1", bus.div_reset, bus.out_valid, bus.in_ready);
    end
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid || bus.div_start) seen = 1'b1;
      tick();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_discard: got activity %b want 0", seen); end
    issue(16'h4600, 16'h4000, 4'd8);
    wait_valid(30, n);
    total++; if (bus.out_result !== 16'h4200 || bus.out_tag !== 4'd8) begin
      bad++; $display("FAIL mid_recover: got %h t%0d want 4200 t8", bus.out_result, bus.out_tag);
    end
    tick();
  endtask

  task automatic test_early_done();
    stub_mode = 2;
    bus.out_ready = 1'b1;
    issue(16'h4600, 16'h4000, 4'd4);
    total++; if (bus.div_start !== 1'b1 || bus.div_done !== 1'b1) begin
      bad++; $display("FAIL early_start: got start %b done %b want 1 1", bus.div_start, bus.div_done);
    end
    tick();
    total++; if (bus.div_reset !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL early_no_capture: got dr%b v%b want 0 0", bus.div_reset, bus.out_valid);
    end
    tick();
    total++; if (bus.div_reset !== 1'b1) begin bad++; $display("FAIL early_clear: got %b want 1", bus.div_reset); end
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h4200 || bus.out_tag !== 4'd4) begin
      bad++; $display("FAIL early_result: got v%b %h t%0d want v1 4200 t4", bus.out_valid, bus.out_result, bus.out_tag);
    end
    tick();
    stub_mode = 0;
  endtask

  task automatic test_timeout();
    int n;
    stub_mode = 1;
    bus.out_ready = 1'b1;
    issue(16'h4600, 16'h4000, 4'd9);
    tick();
    wait_valid(TO + 20, n);
`ifdef FPU_DIV_SEQ_TIMEOUT_EN
    total++; if (n != TO + 2) begin bad++; $display("FAIL to_latency: got %0d want %0d", n, TO + 2); end
    total++; if (bus.out_result !== 16'h7E00 || bus.out_timeout !== 1'b1) begin
      bad++; $display("FAIL to_result: got %h to%b want 7e00 to1", bus.out_result, bus.out_timeout);
    end
    total++; if (bus.out_cond !== 4'b0000 || bus.out_flags !== 5'b10000 || bus.out_tag !== 4'd9) begin
      bad++; $display("FAIL to_status: got %b %b t%0d want 0000 10000 t9", bus.out_cond, bus.out_flags, bus.out_tag);
    end
    tick();
`else
    total++; if (bus.out_valid !== 1'b0 || bus.out_timeout !== 1'b0) begin
      bad++; $display("FAIL to_disabled: got v%b to%b want 0 0", bus.out_valid, bus.out_timeout);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif
    stub_mode = 0;
    issue(16'h4600, 16'h4000, 4'd10);
    wait_valid(30, n);
    total++; if (bus.out_result !== 16'h4200 || bus.out_timeout !== 1'b0 || bus.out_tag !== 4'd10) begin
      bad++; $display("FAIL to_after: got %h to%b t%0d want 4200 to0 t10", bus.out_result, bus.out_timeout, bus.out_tag);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    stub_mode = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_early_done();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_div_sequencer.md
Name: fpu_div_sequencer

Overview:
- Issue/collect stage that sits directly upstream of the fpuDiv coprocessor.
- Accepts operand pairs over a valid/ready handshake and holds them stable on the divider inputs. Pulses the divider's start, waits for its done, then registers result, condition codes and status flags.
- Issues a one-cycle local divider reset between operations, because fpuDiv's FSM parks in DONE.
- Presents the registered result downstream over valid/ready.

Parameters:
- FP_T, fp16_t, floating-point operand/result type (sign/exp/frac struct).
- TAG_W, 4, width of the opaque request tag carried with each operation.
- TIMEOUT_CYCLES, 64, BUSY cycles before the watchdog fires (used only with the optional feature).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- in_a  input  $bits(FP_T)  dividend.
- in_b  input  $bits(FP_T)  divisor.
- in_tag  input  TAG_W  request tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- out_result  output  $bits(FP_T)  quotient.
- out_tag  output  TAG_W  tag of this result.
- out_cond  output  condCode_t  {Z,C,N,V} from divider.
- out_flags  output  opStatusFlag_t  status flags from divider.
- out_timeout  output  1  result was produced by the watchdog.
- div_in1, div_in2  output  $bits(FP_T)  operands to fpuDiv.
- div_start  output  1  start pulse to fpuDiv.
- div_reset  output  1  reset to fpuDiv.
- div_done  input  1  fpuDiv done.
- div_out  input  $bits(FP_T)  fpuDiv result.
- div_cond  input  condCode_t  fpuDiv condition codes.
- div_flags  input  opStatusFlag_t  fpuDiv status flags.

Behaviour:
- Reset values: state IDLE; all output registers 0; out_valid=0; div_start=0; div_reset=1 while reset is high.
- div_reset = reset | (state==CLEAR), decoded from state with no extra register.
- States: IDLE, START, BUSY, CLEAR, RESP.
- IDLE: in_ready=1. On in_valid, latch in_a, in_b, in_tag into operand registers, then go to START.
- START: div_start=1 for exactly one cycle, then go to BUSY.
- BUSY: wait for div_done. In the first cycle it is high, capture div_out, div_cond, div_flags into the output registers, then go to CLEAR.
- CLEAR: div_reset=1 for one cycle, then go to RESP.
- RESP: out_valid=1; outputs held stable until out_ready.
  - out_ready & !in_valid: go to IDLE.
  - out_ready & in_valid: accept the new request in the same cycle (in_ready=1), latch it, go to START. This is back-to-back issue with no IDLE bubble.
- in_ready = (state==IDLE) | (state==RESP & out_ready). Combinational from out_ready only; no path from in_valid.
- div_in1/div_in2 are driven from the operand registers only and are constant from START through CLEAR.
- A div_done already high in START is ignored; done is sampled only in BUSY.
- Latency: acceptance in cycle T gives div_start at T+1. out_valid rises 2 cycles after the cycle div_done is first sampled high in BUSY.
- Reset mid-operation (any state) returns to IDLE on the same edge, discards the op, and resets fpuDiv. No partial result is emitted.
- out_timeout=0 whenever the optional feature is absent.

Optional Feature:
- Macro: FPU_DIV_SEQ_TIMEOUT_EN.
- With the macro:
  - A watchdog counter clears on entry to BUSY and increments each BUSY cycle.
  - If the count reaches TIMEOUT_CYCLES with div_done low, capture the canonical qNaN: sign 0, exp all ones, frac MSB 1, rest 0. For fp16 this is 0x7E00.
  - On timeout: out_cond=0, out_flags with the invalid bit set, out_timeout=1, then proceed to CLEAR.
  - A done and a timeout in the same cycle resolve as done.
- Without the macro: no counter logic; BUSY waits indefinitely; out_timeout tied 0.

Decomposition:
- Shared package: fp16_t, condCode_t, opStatusFlag_t (existing), plus the new fpuDivSeqState_t enum and FPU_QNAN constant.
- One sub-module: fpu_div_seq_wdog (counter with clear/enable/expired), instantiated only under FPU_DIV_SEQ_TIMEOUT_EN.

Test Plan:
- in_a=0x4600 (6.0), in_b=0x4000 (2.0), tag=3, out_ready=1 → out_result=0x4200, out_tag=3, div_start high exactly one cycle, div_reset high exactly one cycle before out_valid.
- 0x3C00/0x4200 (1.0/3.0) with out_ready low for 5 cycles → out_valid held; out_result=0x3555 stable; in_ready=0 throughout.
- Two requests back-to-back (6/2 then 1/3) with out_ready=1 → second accepted in the RESP cycle of the first; results 0x4200 then 0x3555 in order with tags preserved.
- Assert reset for 1 cycle while in BUSY → state IDLE, out_valid=0, no result emitted; next 6/2 request returns 0x4200 normally.
- Divider stub with div_done never high, macro defined → out_valid after TIMEOUT_CYCLES+2 cycles in BUSY, out_result=0x7E00, out_timeout=1. Macro undefined → out_valid stays 0.
- div_done held high by stub during START → no capture until BUSY; out_valid 2 cycles after the first BUSY cycle.
